// File: rtl/sw_pkg.sv
// Shared stopwatch constants: FSM state encoding and BCD digit limits.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd5;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, kHz-sampled debounce,
// one-clk press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic khz_en,
  input  logic btn,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic       level_d;
  logic [3:0] run_cnt;

  localparam logic [3:0] RUN_LAST = 4'(DEBOUNCE_N - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      run_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // run_cnt counts consecutive samples disagreeing with level
      if (khz_en) begin
        if (sync2 == level) begin
          run_cnt <= '0;
        end else if (run_cnt == RUN_LAST) begin
          level   <= sync2;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/clear buttons drive an IDLE/RUN/PAUSE
// FSM gating a BCD mm:ss counter that wraps at 59:59.
module stopwatch_ctrl
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       KHz_enable,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  sw_state_t state;
  logic      start_p;
  logic      clear_p;
  logic      inc;

  btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_start (
    .clk    (clk),
    .rst    (rst),
    .khz_en (KHz_enable),
    .btn    (btn_start),
    .press  (start_p)
  );

  btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_clear (
    .clk    (clk),
    .rst    (rst),
    .khz_en (KHz_enable),
    .btn    (btn_clear),
    .press  (clear_p)
  );

  assign inc = enable && (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      running  <= 1'b0;
      wrap     <= 1'b0;
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else begin
      wrap <= 1'b0;
      // >= keeps any corrupted digit from leaving BCD range
      if (inc) begin
        if (sec_ones >= ONES_MAX) begin
          sec_ones <= '0;
          if (sec_tens >= TENS_MAX) begin
            sec_tens <= '0;
            if (min_ones >= ONES_MAX) begin
              min_ones <= '0;
              if (min_tens >= TENS_MAX) begin
                min_tens <= '0;
                wrap     <= 1'b1;
              end else begin
                min_tens <= min_tens + 3'd1;
              end
            end else begin
              min_ones <= min_ones + 4'd1;
            end
          end else begin
            sec_tens <= sec_tens + 3'd1;
          end
        end else begin
          sec_ones <= sec_ones + 4'd1;
        end
      end
      // clear only acts outside RUN, so it never races the increment
      if (clear_p && state != RUN) begin
        state    <= IDLE;
        running  <= 1'b0;
        min_tens <= '0;
        min_ones <= '0;
        sec_tens <= '0;
        sec_ones <= '0;
      end else if (start_p) begin
        unique case (1'b1)
          (state == RUN): begin
            state   <= PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= RUN;
            running <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with an elapsed-seconds reference
// model checked every cycle, plus literal checkpoints.
module tb_stopwatch_ctrl;

  localparam int N  = 2;
  localparam int KP = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       KHz_enable;
  logic       btn_start;
  logic       btn_clear;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       wrap;

  int n_chk  = 0;
  int n_fail = 0;
  int wrap_seen = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .KHz_enable (KHz_enable),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .wrap       (wrap)
  );

  // reference model: elapsed seconds plus run-length button qualification
  int m_secs = 0;
  int m_st   = M_IDLE;
  bit m_wrap = 1'b0;
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  bit m_lvld[2];
  bit m_press[2];
  bit m_last[2];
  int m_run[2];
  bit btn_in[2];
  bit sp;
  bit cp;

  initial begin
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvld[b] = 0;
      m_press[b] = 0; m_last[b] = 0; m_run[b] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_secs = 0;
        m_st   = M_IDLE;
        m_wrap = 0;
        for (int b = 0; b < 2; b++) begin
          m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvld[b] = 0;
          m_press[b] = 0; m_last[b] = 0; m_run[b] = 0;
        end
      end else begin
        sp = m_press[0];
        cp = m_press[1];
        m_wrap = 0;
        if (enable && m_st == M_RUN) begin
          m_wrap = (m_secs == 3599);
          m_secs = (m_secs + 1) % 3600;
        end
        if (cp && m_st != M_RUN) begin
          m_st   = M_IDLE;
          m_secs = 0;
        end else if (sp) begin
          m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        end
        btn_in[0] = btn_start;
        btn_in[1] = btn_clear;
        for (int b = 0; b < 2; b++) begin
          m_press[b] = m_lvl[b] && !m_lvld[b];
          m_lvld[b]  = m_lvl[b];
          if (KHz_enable) begin
            if (m_run[b] > 0 && m_s2[b] == m_last[b]) m_run[b]++;
            else m_run[b] = 1;
            m_last[b] = m_s2[b];
            if (m_run[b] >= N && m_s2[b] != m_lvl[b]) m_lvl[b] = m_s2[b];
          end
          m_s2[b] = m_s1[b];
          m_s1[b] = btn_in[b];
        end
      end
    end
  end

  function automatic int dut_secs();
    return int'(min_tens) * 600 + int'(min_ones) * 60 +
           int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (wrap) wrap_seen++;
    if (!rst) begin
      n_chk++;
      if (int'(min_tens) != m_secs / 600 ||
          int'(min_ones) != (m_secs / 60) % 10 ||
          int'(sec_tens) != (m_secs % 60) / 10 ||
          int'(sec_ones) != m_secs % 10 ||
          running != (m_st == M_RUN) || wrap != m_wrap) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL model t=%0t got %0d%0d:%0d%0d run=%0b wrap=%0b need secs=%0d run=%0b wrap=%0b",
                   $time, min_tens, min_ones, sec_tens, sec_ones, running, wrap,
                   m_secs, (m_st == M_RUN), m_wrap);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d need %0d", name, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit c);
    @(negedge clk);
    btn_start = s;
    btn_clear = c;
    wait_clks(6 * KP);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    wait_clks(6 * KP);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk); enable = 1'b1;
      @(negedge clk); enable = 1'b0;
    end
    wait_clks(2);
  endtask

  task automatic run_secs(input int n);
    @(negedge clk);
    enable = 1'b1;
    wait_clks(n);
    enable = 1'b0;
    wait_clks(2);
  endtask

  // align a 1 s tick with the cycle the start press pulse is consumed
  task automatic press_start_with_tick();
    bit done;
    done = 1'b0;
    @(negedge clk);
    btn_start = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (m_press[0]) begin
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        done = 1'b1;
      end
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL press_sync got timeout need pulse");
    end
    btn_start = 1'b0;
    wait_clks(6 * KP);
  endtask

  initial begin
    KHz_enable = 1'b0;
    forever begin
      wait_clks(KP - 1);
      KHz_enable = 1'b1;
      @(negedge clk);
      KHz_enable = 1'b0;
    end
  end

  initial begin
    enable = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    rst = 1'b1;
    wait_clks(3);
    chk("reset_secs", dut_secs(), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_wrap", int'(wrap), 0);
    rst = 1'b0;
    wait_clks(4);

    // 3 kHz ticks of start -> RUN, then 5 s
    btn_start = 1'b1;
    wait_clks(3 * KP);
    btn_start = 1'b0;
    wait_clks(6 * KP);
    chk("start_running", int'(running), 1);
    tick(5);
    chk("five_secs", dut_secs(), 5);

    press(1, 0);
    chk("pause_running", int'(running), 0);
    press(0, 1);
    chk("clear_secs", dut_secs(), 0);

    // chatter: alternate every kHz sample
    for (int i = 0; i < 20; i++) begin
      btn_start = ~btn_start;
      wait_clks(KP);
    end
    btn_start = 1'b0;
    wait_clks(6 * KP);
    chk("bounce_running", int'(running), 0);
    chk("bounce_secs", dut_secs(), 0);

    // 01:09 then start press coinciding with enable
    press(1, 0);
    run_secs(69);
    chk("at_0109", dut_secs(), 69);
    press_start_with_tick();
    chk("at_0110", dut_secs(), 70);
    chk("paused", int'(running), 0);
    tick(3);
    chk("pause_holds", dut_secs(), 70);
    press(0, 1);
    chk("clear_0000", dut_secs(), 0);
    press(1, 0);
    tick(4);
    press(0, 1);
    chk("clear_in_run_secs", dut_secs(), 4);
    chk("clear_in_run_running", int'(running), 1);

    // simultaneous presses: RUN -> PAUSE, PAUSE -> IDLE
    press(1, 1);
    chk("both_run_running", int'(running), 0);
    chk("both_run_secs", dut_secs(), 4);
    press(1, 1);
    chk("both_pause_secs", dut_secs(), 0);
    chk("both_pause_running", int'(running), 0);

    // wrap at 59:59
    press(1, 0);
    run_secs(3598);
    chk("at_5958", dut_secs(), 3598);
    wrap_seen = 0;
    tick(1);
    chk("at_5959", dut_secs(), 3599);
    tick(1);
    chk("wrap_0000", dut_secs(), 0);
    chk("wrap_cycles", wrap_seen, 1);
    chk("wrap_running", int'(running), 1);

    // async reset mid-count at 12:34
    run_secs(754);
    chk("at_1234", dut_secs(), 754);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_secs", dut_secs(), 0);
    chk("async_running", int'(running), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_clks(4);

    // button held across reset release must requalify
    @(negedge clk);
    rst = 1'b1;
    btn_start = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    @(negedge clk);
    chk("held_early_running", int'(running), 0);
    wait_clks(6 * KP);
    chk("held_late_running", int'(running), 1);
    btn_start = 1'b0;
    wait_clks(6 * KP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
